aux_slot_host: RTL

- Motherboard-side initiator for the Apple IIe auxiliary-slot DRAM interface; the counterpart of the aux RAM card.
- From C14M it generates the Apple II clock set: C7M, Q3, PHI0 and PHI1.
- It generates the multiplexed DRAM strobes nPRAS/nPCAS, the MA bus, and the control lines nWE, nWE80, nEN80 and nC07X.
- It serves one CPU access per PHI0 phase through a req/ack handshake, and one 80-column video fetch per PHI1 phase.
- Used as the bench/host model and for standalone card bring-up boards.

---
 rtl/aux_slot_host.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/aux_slot_host.sv
// Apple IIe motherboard-side aux-slot initiator: clock set, DRAM strobes, MA mux, CPU/video access.
// Outputs registered on C14M; a CPU req is served in the next PHI0 and acked at the following PHI1 T0.
module aux_slot_host #(
  parameter int LINE_CYCLES = 65,
  parameter bit LONG_EN     = 1'b1
) (
  input  logic        C14M,
  input  logic        nRESET,
  output logic        C7M,
  output logic        Q3,
  output logic        PHI0,
  output logic        PHI1,
  output logic        nPRAS,
  output logic        nPCAS,
  output logic [7:0]  MA,
  output logic        nWE,
  output logic        nWE80,
  output logic        nEN80,
  output logic        nC07X,
  inout  wire  [7:0]  MD,
  input  logic [7:0]  VD,
  input  logic        req,
  input  logic        req_we,
  input  logic        req_aux,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  input  logic        vid_en80,
  input  logic [15:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_valid
);

  localparam int CW = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(LINE_CYCLES - 1);

  // Timing state describes the tick currently on the outputs; ph = 1 means PHI0 phase.
  logic          run_q;
  logic          ph_q, ph_d;
  logic [3:0]    tk_q, tk_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [3:0]    last_cur, last_d;
  logic          end_phi0;

  logic          cvld_q, cwe_q, caux_q;
  logic [15:0]   caddr_q;
  logic [7:0]    cwdata_q;
  logic          ven_q;
  logic [15:0]   vaddr_q;

  logic          c7m_q, q3_q, phi0_q, phi1_q, nras_q, ncas_q;
  logic [7:0]    ma_q;
  logic          nwe_q, nwe80_q, nen80_q, nc07x_q;
  logic          md_oe_q;
  logic [7:0]    md_dat_q;
  logic          ack_q, vvalid_q;
  logic [7:0]    rdata_q, vdata_q;

  logic          cpu_t0, vid_t0;
  logic          e_vld, e_we, e_aux, e_ven;
  logic [15:0]   e_addr, e_vaddr, addr_d;
  logic [7:0]    e_wdata, ma_d;
  logic          wr_d, en_d, strobe_win;

  always_comb begin
    last_cur = (ph_q && LONG_EN && cyc_q == CYC_LAST) ? 4'd8 : 4'd6;
    end_phi0 = run_q && ph_q && (tk_q == last_cur);
    ph_d  = ph_q;
    tk_d  = tk_q + 4'd1;
    cyc_d = cyc_q;
    if (!run_q) begin
      ph_d = 1'b0;
      tk_d = 4'd0;
    end else if (tk_q == last_cur) begin
      ph_d = ~ph_q;
      tk_d = 4'd0;
      if (ph_q) cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + CW'(1);
    end
    last_d = (ph_d && LONG_EN && cyc_d == CYC_LAST) ? 4'd8 : 4'd6;
  end

  // At T0 the live inputs are used so the outputs of that tick already reflect the capture.
  always_comb begin
    cpu_t0     = ph_d && (tk_d == 4'd0);
    vid_t0     = !ph_d && (tk_d == 4'd0);
    e_vld      = cpu_t0 ? req       : cvld_q;
    e_we       = cpu_t0 ? req_we    : cwe_q;
    e_aux      = cpu_t0 ? req_aux   : caux_q;
    e_addr     = cpu_t0 ? req_addr  : caddr_q;
    e_wdata    = cpu_t0 ? req_wdata : cwdata_q;
    e_ven      = vid_t0 ? vid_en80  : ven_q;
    e_vaddr    = vid_t0 ? vid_addr  : vaddr_q;
    strobe_win = tk_d < last_d;
    addr_d     = ph_d ? (e_vld ? e_addr : 16'h0000) : e_vaddr;
    ma_d       = (tk_d < 4'd3) ? addr_d[7:0] : addr_d[15:8];
    wr_d       = ph_d && e_vld && e_we;
    en_d       = ph_d ? (e_vld && e_aux) : e_ven;
  end

  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET) begin
      run_q    <= 1'b0;
      ph_q     <= 1'b0;
      tk_q     <= 4'd0;
      cyc_q    <= '0;
      cvld_q   <= 1'b0;
      cwe_q    <= 1'b0;
      caux_q   <= 1'b0;
      caddr_q  <= 16'h0000;
      cwdata_q <= 8'h00;
      ven_q    <= 1'b0;
      vaddr_q  <= 16'h0000;
      c7m_q    <= 1'b0;
      q3_q     <= 1'b0;
      phi0_q   <= 1'b0;
      phi1_q   <= 1'b1;
      nras_q   <= 1'b1;
      ncas_q   <= 1'b1;
      ma_q     <= 8'h00;
      nwe_q    <= 1'b1;
      nwe80_q  <= 1'b1;
      nen80_q  <= 1'b1;
      nc07x_q  <= 1'b1;
      md_oe_q  <= 1'b0;
      md_dat_q <= 8'h00;
      ack_q    <= 1'b0;
      vvalid_q <= 1'b0;
      rdata_q  <= 8'h00;
      vdata_q  <= 8'h00;
    end else begin
      run_q <= 1'b1;
      ph_q  <= ph_d;
      tk_q  <= tk_d;
      cyc_q <= cyc_d;
      if (cpu_t0) begin
        cvld_q   <= req;
        cwe_q    <= req_we;
        caux_q   <= req_aux;
        caddr_q  <= req_addr;
        cwdata_q <= req_wdata;
      end
      if (vid_t0) begin
        ven_q   <= vid_en80;
        vaddr_q <= vid_addr;
      end
      c7m_q    <= ~c7m_q;
      q3_q     <= tk_d < 4'd4;
      phi0_q   <= ph_d;
      phi1_q   <= ~ph_d;
      nras_q   <= !((tk_d >= 4'd1) && strobe_win);
      ncas_q   <= !((tk_d >= 4'd3) && strobe_win);
      ma_q     <= ma_d;
      nwe_q    <= !(wr_d && strobe_win);
      nwe80_q  <= !(wr_d && e_aux && strobe_win);
      nen80_q  <= !(en_d && strobe_win);
      nc07x_q  <= !(ph_d && e_vld && (e_addr[15:4] == 12'hC07));
      md_oe_q  <= wr_d && (tk_d != 4'd0);
      md_dat_q <= e_wdata;
      // Read data and the video byte are taken on the edge that closes PHI0.
      ack_q    <= end_phi0 && cvld_q;
      vvalid_q <= end_phi0 && ven_q;
      if (end_phi0 && cvld_q && !cwe_q) rdata_q <= MD;
      if (end_phi0 && ven_q) vdata_q <= VD;
    end
  end

  assign MD        = md_oe_q ? md_dat_q : 8'hzz;
  assign C7M       = c7m_q;
  assign Q3        = q3_q;
  assign PHI0      = phi0_q;
  assign PHI1      = phi1_q;
  assign nPRAS     = nras_q;
  assign nPCAS     = ncas_q;
  assign MA        = ma_q;
  assign nWE       = nwe_q;
  assign nWE80     = nwe80_q;
  assign nEN80     = nen80_q;
  assign nC07X     = nc07x_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign vid_data  = vdata_q;
  assign vid_valid = vvalid_q;

endmodule
